// File: rtl/qec_stream_pkg.sv
// ============================================================================
// Module      : qec_stream_pkg
// Description : Shared state encoding and width helper for QEC stream blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package qec_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } stream_state_e;

    // Index width for a stream of n rounds; never narrower than one bit.
    function automatic int ridx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/error_round_serializer.sv
// ============================================================================
// Module      : error_round_serializer
// Description : Captures one batch of error bits and emits it round by round
//               over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module error_round_serializer #(
    parameter int MEASUREMENT_ROUNDS = 5,
    parameter int RIDX_W             = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic [MEASUREMENT_ROUNDS-1:0] data_in,
    input  logic                          round_ready,
    output logic                          round_bit,
    output logic [RIDX_W-1:0]             round_index,
    output logic                          round_valid,
    output logic                          transfer,
    output logic                          last_accept
);

    localparam logic [RIDX_W-1:0] c_last_idx = RIDX_W'(MEASUREMENT_ROUNDS - 1);

    logic [MEASUREMENT_ROUNDS-1:0] r_cap;
    logic [RIDX_W-1:0]             r_idx;
    logic                          r_valid;

    assign transfer    = r_valid && round_ready;
    assign last_accept = transfer && (r_idx == c_last_idx);
    assign round_bit   = r_cap[r_idx];
    assign round_index = r_idx;
    assign round_valid = r_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cap   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else if (load) begin
            r_cap   <= data_in;
            r_idx   <= '0;
            r_valid <= 1'b1;
        end else if (transfer) begin
            // Index returns to 0 after the last round so the next batch starts clean.
            if (r_idx == c_last_idx) begin
                r_idx   <= '0;
                r_valid <= 1'b0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/error_stream_reader.sv
// ============================================================================
// Module      : error_stream_reader
// Description : Requests error batches from the producer, serialises them per
//               round and keeps saturating batch/error statistics for a run.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module error_stream_reader
    import qec_stream_pkg::*;
#(
    parameter int MEASUREMENT_ROUNDS = 5,
    parameter int COUNT_WIDTH        = 32,
    parameter int RIDX_W             = ridx_width(MEASUREMENT_ROUNDS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [COUNT_WIDTH-1:0]        num_batches,
    input  logic                          update_valid,
    input  logic [MEASUREMENT_ROUNDS-1:0] error_stream,
    output logic                          update_errors,
    output logic                          round_bit,
    output logic [RIDX_W-1:0]             round_index,
    output logic                          round_valid,
    input  logic                          round_ready,
    output logic [COUNT_WIDTH-1:0]        batch_count,
    output logic [COUNT_WIDTH-1:0]        error_count,
    output logic                          busy,
    output logic                          done
);

    stream_state_e          r_state;
    logic [COUNT_WIDTH-1:0] r_num;
    logic [COUNT_WIDTH-1:0] r_batch;
    logic [COUNT_WIDTH-1:0] r_err;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_transfer;
    logic                   w_last_accept;
    logic [COUNT_WIDTH-1:0] w_batch_next;

    // Refill request is combinational so the producer sees consume in the same cycle.
    assign update_errors = (r_state == ST_WAIT) && update_valid;
    assign w_batch_next  = (r_batch == '1) ? r_batch : r_batch + 1'b1;

    assign batch_count = r_batch;
    assign error_count = r_err;
    assign busy        = r_busy;
    assign done        = r_done;

    error_round_serializer #(
        .MEASUREMENT_ROUNDS (MEASUREMENT_ROUNDS),
        .RIDX_W             (RIDX_W)
    ) u_serializer (
        .clk         (clk),
        .reset       (reset),
        .load        (update_errors),
        .data_in     (error_stream),
        .round_ready (round_ready),
        .round_bit   (round_bit),
        .round_index (round_index),
        .round_valid (round_valid),
        .transfer    (w_transfer),
        .last_accept (w_last_accept)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_num   <= '0;
            r_batch <= '0;
            r_err   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            if (w_transfer && round_bit && (r_err != '1)) begin
                r_err <= r_err + 1'b1;
            end
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_num   <= num_batches;
                        r_batch <= '0;
                        r_err   <= '0;
                        if (num_batches == '0) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (update_valid) begin
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_last_accept) begin
                        r_batch <= w_batch_next;
                        if (w_batch_next == r_num) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_error_stream_reader.sv
// ============================================================================
// Module      : tb_error_stream_reader
// Description : Directed self-checking bench with a behavioural run model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_error_stream_reader;

    localparam int MR = 5;
    localparam int CW = 32;
    localparam int RW = 3;
    localparam longint MAXC = 64'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] num_batches = '0;
    logic          update_valid = 1'b0;
    logic [MR-1:0] error_stream = '0;
    logic          update_errors;
    logic          round_bit;
    logic [RW-1:0] round_index;
    logic          round_valid;
    logic          round_ready;
    logic [CW-1:0] batch_count;
    logic [CW-1:0] error_count;
    logic          busy;
    logic          done;

    // Small-counter instance for the saturation case.
    logic          s_start = 1'b0;
    logic [3:0]    s_num = '0;
    logic          s_update_errors;
    logic          s_round_bit;
    logic [RW-1:0] s_round_index;
    logic          s_round_valid;
    logic [3:0]    s_batch;
    logic [3:0]    s_err;
    logic          s_busy;
    logic          s_done;

    int vectors = 0;
    int miscompares = 0;

    int   ready_mode = 0;
    logic ready_manual = 1'b0;
    int   ready_phase = 0;
    int   pulses = 0;
    logic accepted [$];

    always #5 clk = ~clk;

    error_stream_reader #(.MEASUREMENT_ROUNDS(MR), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .num_batches(num_batches),
        .update_valid(update_valid), .error_stream(error_stream),
        .update_errors(update_errors), .round_bit(round_bit),
        .round_index(round_index), .round_valid(round_valid),
        .round_ready(round_ready), .batch_count(batch_count),
        .error_count(error_count), .busy(busy), .done(done)
    );

    error_stream_reader #(.MEASUREMENT_ROUNDS(MR), .COUNT_WIDTH(4)) dut_sat (
        .clk(clk), .reset(reset), .start(s_start), .num_batches(s_num),
        .update_valid(1'b1), .error_stream(5'b11111),
        .update_errors(s_update_errors), .round_bit(s_round_bit),
        .round_index(s_round_index), .round_valid(s_round_valid),
        .round_ready(1'b1), .batch_count(s_batch),
        .error_count(s_err), .busy(s_busy), .done(s_done)
    );

    task automatic check(input string name, input longint actual, input longint expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Ready pattern source: always-ready, a 1,0,0 stall pattern, or manual.
    always @(negedge clk) begin
        #1;
        ready_phase = (ready_phase + 1) % 3;
        case (ready_mode)
            0: round_ready = 1'b1;
            1: round_ready = (ready_phase == 0);
            default: round_ready = ready_manual;
        endcase
    end

    // Run model: phase 0 idle, 1 waiting for a batch, 2 streaming, 3 finished.
    int          m_phase = 0;
    longint      m_num = 0, m_bc = 0, m_ec = 0;
    logic [MR-1:0] m_bits = '0;
    int          m_idx = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = 0; m_num = 0; m_bc = 0; m_ec = 0; m_bits = '0; m_idx = 0;
        end else begin
            case (m_phase)
                0, 3: if (start) begin
                    m_num = num_batches; m_bc = 0; m_ec = 0;
                    m_phase = (num_batches == 0) ? 3 : 1;
                end
                1: if (update_valid) begin
                    m_bits = error_stream; m_idx = 0; m_phase = 2;
                end
                default: if (round_ready) begin
                    m_ec = (m_ec + m_bits[m_idx] > MAXC) ? MAXC : m_ec + m_bits[m_idx];
                    if (m_idx == MR - 1) begin
                        m_bc = (m_bc + 1 > MAXC) ? MAXC : m_bc + 1;
                        m_idx = 0;
                        m_phase = (m_bc == m_num) ? 3 : 1;
                    end else begin
                        m_idx++;
                    end
                end
            endcase
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            if (update_errors) pulses++;
            if (round_valid && round_ready) accepted.push_back(round_bit);
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (!reset) begin
            check("update_errors", update_errors, (m_phase == 1) && update_valid);
            check("round_valid", round_valid, m_phase == 2);
            check("busy", busy, (m_phase == 1) || (m_phase == 2));
            check("done", done, m_phase == 3);
            check("batch_count", batch_count, m_bc);
            check("error_count", error_count, m_ec);
            if (m_phase == 2) begin
                check("round_bit", round_bit, m_bits[m_idx]);
                check("round_index", round_index, m_idx);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic pulse_start(input logic [CW-1:0] n);
        step();
        start = 1'b1;
        num_batches = n;
        step();
        start = 1'b0;
    endtask

    task automatic give_batch(input logic [MR-1:0] bits, input bit keep_valid);
        bit seen = 0;
        update_valid = 1'b1;
        error_stream = bits;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (update_errors) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check("update_errors_seen", seen, 1);
        @(posedge clk);
        #1;
        if (!keep_valid) update_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        check("done_within_budget", seen, 1);
    endtask

    task automatic check_bits(input logic [MR-1:0] bits);
        check("accepted_count", accepted.size(), MR);
        for (int i = 0; i < MR && i < accepted.size(); i++)
            check("accepted_bit", accepted[i], bits[i]);
    endtask

    initial begin
        round_ready = 1'b1;
        #1;
        check("reset_update_errors", update_errors, 0);
        check("reset_round_valid", round_valid, 0);
        check("reset_round_index", round_index, 0);
        check("reset_done", done, 0);
        check("reset_busy", busy, 0);
        check("reset_error_count", error_count, 0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;

        // Single batch, always ready.
        accepted.delete(); pulses = 0;
        pulse_start(1);
        give_batch(5'b10110, 0);
        wait_done();
        check("single_batch_count", batch_count, 1);
        check("single_error_count", error_count, 3);
        check("single_pulses", pulses, 1);
        check_bits(5'b10110);

        // Same batch under backpressure.
        accepted.delete(); pulses = 0;
        ready_mode = 1;
        pulse_start(1);
        give_batch(5'b10110, 0);
        wait_done();
        check("bp_error_count", error_count, 3);
        check_bits(5'b10110);
        ready_mode = 0;

        // Three batches.
        pulses = 0;
        pulse_start(3);
        give_batch(5'b00001, 0);
        give_batch(5'b00000, 0);
        give_batch(5'b11111, 0);
        wait_done();
        check("multi_error_count", error_count, 6);
        check("multi_batch_count", batch_count, 3);
        check("multi_pulses", pulses, 3);

        // Zero-batch run finishes immediately.
        pulses = 0;
        pulse_start(0);
        check("zero_done", done, 1);
        check("zero_counts", batch_count + error_count, 0);
        repeat (3) step();
        check("zero_pulses", pulses, 0);

        // Slow producer, with a start while busy.
        pulse_start(1);
        repeat (5) step();
        start = 1'b1; num_batches = 7;
        step();
        start = 1'b0;
        repeat (14) step();
        check("slow_busy", busy, 1);
        check("slow_round_valid", round_valid, 0);
        give_batch(5'b00100, 0);
        wait_done();
        check("slow_batch_count", batch_count, 1);
        check("slow_error_count", error_count, 1);

        // Reset in STREAM at round 2, producer left valid.
        ready_mode = 2; ready_manual = 1'b0;
        pulse_start(1);
        give_batch(5'b01011, 1);
        ready_manual = 1'b1;
        @(posedge clk); @(posedge clk);
        #1 ready_manual = 1'b0;
        @(negedge clk);
        check("pre_reset_index", round_index, 2);
        #2 reset = 1'b1;
        #1;
        check("async_round_valid", round_valid, 0);
        check("async_round_index", round_index, 0);
        check("async_busy", busy, 0);
        check("async_counts", batch_count + error_count, 0);
        step();
        reset = 1'b0;
        ready_mode = 0;
        pulse_start(1);
        give_batch(5'b01011, 0);
        wait_done();
        check("after_reset_batch_count", batch_count, 1);
        check("after_reset_error_count", error_count, 3);

        // Four all-ones batches into a 4-bit counter: 20 errors saturate at 15.
        step();
        s_start = 1'b1; s_num = 4'd4;
        step();
        s_start = 1'b0;
        begin
            bit seen = 0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (s_done) begin
                    seen = 1;
                    break;
                end
            end
            check("sat_done", seen, 1);
        end
        check("sat_error_count", s_err, 15);
        check("sat_batch_count", s_batch, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
